acorn128_tag_verify: RTL
========================

// Module: acorn128_tag_verify
// PURPOSE
//  Post-processing stage after the ACORN-128 core. Takes one operation request (mode plus expected
//  tag), waits for the core's ready_out rising edge, and captures the core's 128-bit data and tag.
//  Compares tags over a fixed cycle count with no early exit, and releases the result only on auth pass.
//  Feeds the host result interface through a valid/accept handshake.
// PARAMETERS
//  CHUNK_W   8     bits compared per cycle; must divide 128; N = 128/CHUNK_W compare cycles
//  WAIT_MAX  4095  max clocks in WAIT_CORE before timeout; 12-bit counter; must be >= 1
// PORTS
//  clk             in   1    single clock, rising edge
//  rst             in   1    asynchronous, active-high reset
//  op_valid_in     in   1    operation request valid
//  op_ready_out    out  1    request accepted when valid&ready; high only in IDLE
//  op_encrypt_in   in   1    1 = encrypt (no tag check), 0 = decrypt; sampled at accept
//  exp_tag_in      in   128  expected tag for decrypt; sampled at accept
//  core_ready_in   in   1    core ready_out
//  core_data_in    in   128  core ciphertext_out|plaintext_out (OR of both, one is always zero)
//  core_tag_in     in   128  core tag_out
//  res_valid_out   out  1    result valid; held until accepted
//  res_accept_in   in   1    host takes result when res_valid_out & res_accept_in
//  res_data_out    out  128  ciphertext (enc) / plaintext (dec pass); 0 on fail or timeout
//  res_tag_out     out  128  captured core tag; 0 on timeout
//  auth_ok_out     out  1    1 = enc done or dec tag match; 0 otherwise
//  timeout_out     out  1    1 = core never produced a ready edge within WAIT_MAX
//  fail_cnt_out    out  8    saturating auth-failure count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; op_ready_out=1; res_valid_out=0; all data/tag/flag outputs 0; ready_q=0;
//    wait counter=0; chunk index=0; diff accumulator=0; fail_cnt=0. Mid-op reset aborts the
//    operation; no partial result is ever presented.
//  - ready_q <= core_ready_in every cycle. ready_edge = core_ready_in & ~ready_q.
//  - IDLE: on op_valid_in, latch mode and exp_tag, clear the wait counter, go to WAIT_CORE.
//  - WAIT_CORE: the counter increments each cycle.
//    On ready_edge: capture core_data_in and core_tag_in, clear diff and index, go to COMPARE.
//    When the counter reaches WAIT_MAX-1 without an edge: go to DONE with timeout=1, auth_ok=0,
//    and data/tag outputs 0. A ready_edge in the same cycle as expiry wins (capture, no timeout).
//    If core_ready_in is already high when the op is accepted, there is no edge, so timeout occurs.
//  - COMPARE: exactly N cycles.
//    Chunk i = bits [i*CHUNK_W +: CHUNK_W], LSB chunk first.
//    diff |= |(cap_tag[i] ^ exp_tag[i]); no early exit.
//    Encrypt runs the same N cycles, so latency is mode-independent.
//  - After chunk N-1: go to DONE.
//    Encrypt: auth_ok=1.
//    Decrypt: auth_ok = ~diff.
//    res_data = auth_ok ? cap_data : 0.
//    res_tag = cap_tag in both cases.
//  - Latency: res_valid_out rises N+1 clocks after the edge that samples ready_edge
//    (17 for CHUNK_W=8).
//  - DONE: res_valid_out=1 and all result outputs stable until res_accept_in.
//    On accept, go to IDLE the next cycle and hold result outputs at their last values.
//    A new op is accepted no earlier than the cycle after DONE is left.
//  - A res_accept_in received while res_valid_out=0 is ignored.
//  - Captured data/tag registers are zeroed on entry to IDLE (no key-stream residue).
// CONFIGURATION
//  ACORN_TAG_FAIL_CNT_EN defined:
//    fail_cnt increments by 1 when DONE is entered with auth_ok=0 (decrypt mismatch or timeout).
//    It saturates at 8'hFF, clears only on rst, and fail_cnt_out = fail_cnt.
//  ACORN_TAG_FAIL_CNT_EN undefined:
//    No counter logic is built, and fail_cnt_out is tied to 8'h00.
// TESTING
//  1 enc: exp_tag=X; core pulses ready with data=128'hA5.., tag=T
//    -> res_data=128'hA5.., res_tag=T, auth_ok=1, valid at +17.
//  2 dec match: exp_tag=T, core tag=T, data=P -> res_data=P, auth_ok=1, timeout=0.
//  3 dec mismatch, MSB only: exp_tag=T^(1<<127) -> res_data=0, auth_ok=0, valid still at +17;
//    fail_cnt_out=1 if macro defined, else 0.
//  4 timeout: WAIT_MAX=16, core_ready_in held 0 -> DONE after 16 clocks, timeout=1, all data 0.
//    Variant: ready edge on the expiry cycle -> normal compare, timeout=0.
//  5 backpressure/reset: hold res_accept_in=0 for 50 cycles -> outputs stable.
//    Then assert rst during COMPARE of a new op -> op_ready_out=1, res_valid_out=0, outputs 0.
//  6 ready already high at accept -> no capture, timeout=1; 256 mismatches -> fail_cnt_out=8'hFF.

Source files
------------

// File: rtl/acorn128_tag_verify_if.sv
// Operation-request, core-capture and host-result signals of acorn128_tag_verify.
// slave = the verify block, master = host/core side.
interface acorn128_tag_verify_if;
  logic         op_valid_in;
  logic         op_ready_out;
  logic         op_encrypt_in;
  logic [127:0] exp_tag_in;
  logic         core_ready_in;
  logic [127:0] core_data_in;
  logic [127:0] core_tag_in;
  logic         res_valid_out;
  logic         res_accept_in;
  logic [127:0] res_data_out;
  logic [127:0] res_tag_out;
  logic         auth_ok_out;
  logic         timeout_out;
  logic [7:0]   fail_cnt_out;

  modport slave (
    input  op_valid_in, op_encrypt_in, exp_tag_in,
    input  core_ready_in, core_data_in, core_tag_in,
    input  res_accept_in,
    output op_ready_out, res_valid_out, res_data_out, res_tag_out,
    output auth_ok_out, timeout_out, fail_cnt_out
  );

  modport master (
    output op_valid_in, op_encrypt_in, exp_tag_in,
    output core_ready_in, core_data_in, core_tag_in,
    output res_accept_in,
    input  op_ready_out, res_valid_out, res_data_out, res_tag_out,
    input  auth_ok_out, timeout_out, fail_cnt_out
  );
endinterface

// File: rtl/acorn128_tag_verify.sv
// ACORN-128 tag verify: capture core result, constant-time tag compare, gated release.
// Optional saturating auth-failure counter built when ACORN_TAG_FAIL_CNT_EN is defined.
module acorn128_tag_verify #(
  parameter int unsigned CHUNK_W  = 8,
  parameter int unsigned WAIT_MAX = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  acorn128_tag_verify_if.slave bus
);
  localparam int unsigned N     = 128 / CHUNK_W;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [11:0]      WAIT_LAST = 12'(WAIT_MAX - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_CORE, S_COMPARE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             ready_q;
  logic             ready_edge;
  logic             mode_enc_q, mode_enc_d;
  logic [127:0]     exp_tag_q, exp_tag_d;
  logic [127:0]     cap_data_q, cap_data_d;
  logic [127:0]     cap_tag_q, cap_tag_d;
  logic [11:0]      wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             diff_q, diff_d;
  logic             res_valid_q, res_valid_d;
  logic [127:0]     res_data_q, res_data_d;
  logic [127:0]     res_tag_q, res_tag_d;
  logic             auth_ok_q, auth_ok_d;
  logic             timeout_q, timeout_d;
  logic [127:0]     tag_xor;
  logic             chunk_diff;
  logic             res_hs;
  logic             done_enter;

  assign ready_edge = bus.core_ready_in & ~ready_q;
  assign tag_xor    = cap_tag_q ^ exp_tag_q;
  assign chunk_diff = |tag_xor[idx_q*CHUNK_W +: CHUNK_W];
  assign res_hs     = res_valid_q & bus.res_accept_in;

  always_comb begin
    state_d     = state_q;
    mode_enc_d  = mode_enc_q;
    exp_tag_d   = exp_tag_q;
    cap_data_d  = cap_data_q;
    cap_tag_d   = cap_tag_q;
    wait_cnt_d  = wait_cnt_q;
    idx_d       = idx_q;
    diff_d      = diff_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    auth_ok_d   = auth_ok_q;
    timeout_d   = timeout_q;
    done_enter  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.op_valid_in) begin
          mode_enc_d = bus.op_encrypt_in;
          exp_tag_d  = bus.exp_tag_in;
          wait_cnt_d = '0;
          state_d    = S_WAIT_CORE;
        end
      end
      S_WAIT_CORE: begin
        wait_cnt_d = wait_cnt_q + 12'd1;
        // A ready edge on the expiry cycle takes priority over the timeout.
        if (ready_edge) begin
          cap_data_d = bus.core_data_in;
          cap_tag_d  = bus.core_tag_in;
          diff_d     = 1'b0;
          idx_d      = '0;
          state_d    = S_COMPARE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d  = 1'b1;
          auth_ok_d  = 1'b0;
          res_data_d = '0;
          res_tag_d  = '0;
          done_enter = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_COMPARE: begin
        diff_d = diff_q | chunk_diff;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          timeout_d  = 1'b0;
          auth_ok_d  = mode_enc_q | ~diff_d;
          res_data_d = auth_ok_d ? cap_data_q : '0;
          res_tag_d  = cap_tag_q;
          done_enter = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        // Valid rises one cycle after DONE entry, from the registered results.
        res_valid_d = ~res_hs;
        if (res_hs) begin
          cap_data_d = '0;
          cap_tag_d  = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      mode_enc_q  <= 1'b0;
      exp_tag_q   <= '0;
      cap_data_q  <= '0;
      cap_tag_q   <= '0;
      wait_cnt_q  <= '0;
      idx_q       <= '0;
      diff_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      auth_ok_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= bus.core_ready_in;
      mode_enc_q  <= mode_enc_d;
      exp_tag_q   <= exp_tag_d;
      cap_data_q  <= cap_data_d;
      cap_tag_q   <= cap_tag_d;
      wait_cnt_q  <= wait_cnt_d;
      idx_q       <= idx_d;
      diff_q      <= diff_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      auth_ok_q   <= auth_ok_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef ACORN_TAG_FAIL_CNT_EN
  logic [7:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (done_enter && !auth_ok_d && (fail_cnt_q != 8'hFF))
      fail_cnt_d = fail_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fail_cnt_q <= '0;
    else     fail_cnt_q <= fail_cnt_d;
  end

  assign bus.fail_cnt_out = fail_cnt_q;
`else
  logic unused_fail;
  assign unused_fail      = done_enter;
  assign bus.fail_cnt_out = '0;
`endif

  assign bus.op_ready_out  = (state_q == S_IDLE);
  assign bus.res_valid_out = res_valid_q;
  assign bus.res_data_out  = res_data_q;
  assign bus.res_tag_out   = res_tag_q;
  assign bus.auth_ok_out   = auth_ok_q;
  assign bus.timeout_out   = timeout_q;
endmodule
